operand_fetch: RTL
==================

# operand_fetch

Operand-fetch stage between instruction fetch and execute in the RISC-V core. Accepts one instruction over a valid/ready handshake and reads rs1/rs2 from the block-RAM register file, which has 1-cycle read latency and shares its port B between read-2 and write. Forwards writeback data that lands after the read, and presents the instruction plus both operands to execute over a second valid/ready handshake. Also arbitrates the register file's shared port, with writeback always taking priority.

## Interface
- No parameters.
- Clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush_in  in  1  synchronous squash of the in-flight instruction
- instr_in  in  32  instruction word; rs1 = [19:15], rs2 = [24:20]
- instr_valid_in  in  1  upstream has an instruction
- instr_ready_out  out  1  stage can accept an instruction
- wb_addr_in  in  5  writeback destination register
- wb_data_in  in  32  writeback data
- wb_en_in  in  1  writeback request
- read_addr_1_out  out  5  register-file port A address
- read_addr_2_out  out  5  register-file read-2 address (port B)
- read_en_out  out  1  register-file read enable
- write_addr_out  out  5  register-file write address (port B)
- write_data_out  out  32  register-file write data
- write_en_out  out  1  register-file write enable
- en_reg_file_out  out  1  register-file global enable
- read_data_1_in  in  32  port A read data, valid 1 cycle after the read
- read_data_2_in  in  32  port B read data, valid 1 cycle after the read
- instr_out  out  32  held instruction
- rs1_data_out  out  32  operand 1
- rs2_data_out  out  32  operand 2
- op_valid_out  out  1  operands valid
- op_ready_in  in  1  execute accepts the operands

## Operation
- Writeback path is combinational:
  - wb_eff = wb_en_in & (wb_addr_in != 0).
  - write_en_out = wb_eff; write_addr_out = wb_addr_in; write_data_out = wb_data_in.
  - Writes to x0 are dropped.
- Read addresses always come from the held instruction: read_addr_1_out = instr_q[19:15], read_addr_2_out = instr_q[24:20].
- read_en_out = (state == READ) & !wb_eff.
- en_reg_file_out = read_en_out | write_en_out.
- read_en_out and write_en_out are never high in the same cycle.
- FSM states: IDLE, READ, WAIT, VALID.
  - IDLE: instr_ready_out = 1. On instr_valid_in, latch instr_in into instr_q and go to READ.
  - READ: if wb_eff, the write uses port B; stay in READ (stall). Otherwise issue the read and go to WAIT.
  - WAIT: capture operands and go to VALID. For each operand, in priority order:
    1. source = x0 → 0.
    2. wb_eff and wb_addr_in = source → wb_data_in.
    3. Otherwise → read_data_n_in.
  - VALID: op_valid_out = 1. While held, any wb_eff whose address matches rs1 or rs2 (nonzero) overwrites that operand register. On op_ready_in, go to IDLE.
- instr_out = instr_q.
- Both operands are always fetched; no decode of whether rs2 is used.
- A write in the same cycle as the read cannot happen: READ stalls on wb_eff.
- flush_in has priority over every transition except reset:
  - Go to IDLE and clear op_valid_out.
  - Captured data is not cleared.
  - The writeback port is unaffected.

## Timing
- Reset values:
  - state = IDLE; instr_q = 0; rs1/rs2 registers = 0; op_valid_out = 0; read_en_out = 0.
  - instr_ready_out = 1.
  - Write outputs follow their inputs combinationally.
- Latency with no stalls: instruction accepted at edge N → READ in cycle N+1 → WAIT in N+2 → op_valid_out high from cycle N+3.
- Maximum throughput is 1 instruction per 4 cycles. Each cycle with wb_eff in READ adds 1 cycle.
- op_valid_out stays high and the outputs stay stable while op_ready_in is low, except for the forwarding updates described in Operation.
- Handshakes complete on the edge where valid & ready are both high.
- instr_ready_out is low in READ, WAIT and VALID.
- Reset during any state behaves as full reset at that edge. flush_in together with instr_valid_in in IDLE: the instruction is not accepted.

## Test plan
- Reset, then instr_in with rs1 = 3, rs2 = 5; register file holds x3 = 0x11, x5 = 0x22; op_ready_in = 1 → op_valid_out rises 3 cycles after acceptance with rs1 = 0x11, rs2 = 0x22; returns to IDLE.
- wb_en_in = 1 (addr 7, data 0xAA) held for 2 cycles during READ → read_en_out stays low for those cycles, write_en_out high; op_valid_out is delayed by 2 cycles.
- wb write to x5 = 0x99 in the WAIT cycle when rs2 = 5 → rs2_data_out = 0x99, not the stale RAM value.
- Instruction with rs1 = 0 while the RAM returns 0xDEAD, plus wb_addr_in = 0 → rs1_data_out = 0; write_en_out = 0; read is not stalled.
- op_ready_in low for 5 cycles in VALID, with a wb to rs1 (0x1234) in cycle 2 → rs1_data_out = 0x1234 from the next cycle; the instruction is consumed when ready rises.
- flush_in asserted in WAIT → IDLE next cycle; op_valid_out never rises; instr_ready_out = 1.

Source files
------------

// File: rtl/operand_fetch.sv
//============================================================================
// Module      : operand_fetch
// Description : Operand-fetch stage. Latches one instruction, reads rs1/rs2
//               from a 1-cycle-latency block-RAM register file whose port B
//               is shared between read-2 and write, forwards late writeback
//               data into the captured operands, and hands instruction plus
//               operands to execute over a valid/ready handshake.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_in,
  input  logic [31:0] instr_in,
  input  logic        instr_valid_in,
  output logic        instr_ready_out,
  input  logic [4:0]  wb_addr_in,
  input  logic [31:0] wb_data_in,
  input  logic        wb_en_in,
  output logic [4:0]  read_addr_1_out,
  output logic [4:0]  read_addr_2_out,
  output logic        read_en_out,
  output logic [4:0]  write_addr_out,
  output logic [31:0] write_data_out,
  output logic        write_en_out,
  output logic        en_reg_file_out,
  input  logic [31:0] read_data_1_in,
  input  logic [31:0] read_data_2_in,
  output logic [31:0] instr_out,
  output logic [31:0] rs1_data_out,
  output logic [31:0] rs2_data_out,
  output logic        op_valid_out,
  input  logic        op_ready_in
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_instr;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic        r_op_valid;

  logic        w_wb_eff;
  logic [4:0]  w_rs1_addr;
  logic [4:0]  w_rs2_addr;
  logic [31:0] w_rs1_cap;
  logic [31:0] w_rs2_cap;

  // Writes to x0 never reach the register file and never forward.
  assign w_wb_eff   = wb_en_in & (wb_addr_in != 5'd0);
  assign w_rs1_addr = r_instr[19:15];
  assign w_rs2_addr = r_instr[24:20];

  // Writeback owns port B whenever it is active, so the read backs off.
  assign write_en_out    = w_wb_eff;
  assign write_addr_out  = wb_addr_in;
  assign write_data_out  = wb_data_in;
  assign read_addr_1_out = w_rs1_addr;
  assign read_addr_2_out = w_rs2_addr;
  assign read_en_out     = (r_state == S_READ) & ~w_wb_eff;
  assign en_reg_file_out = read_en_out | write_en_out;

  assign instr_ready_out = (r_state == S_IDLE);
  assign instr_out       = r_instr;
  assign rs1_data_out    = r_rs1_data;
  assign rs2_data_out    = r_rs2_data;
  assign op_valid_out    = r_op_valid;

  // Operand selection in the capture cycle: x0, then same-cycle writeback,
  // then the RAM data that was read in the previous cycle.
  always_comb begin
    w_rs1_cap = read_data_1_in;
    w_rs2_cap = read_data_2_in;
    if (w_rs1_addr == 5'd0) begin
      w_rs1_cap = 32'd0;
    end else if (w_wb_eff && (wb_addr_in == w_rs1_addr)) begin
      w_rs1_cap = wb_data_in;
    end
    if (w_rs2_addr == 5'd0) begin
      w_rs2_cap = 32'd0;
    end else if (w_wb_eff && (wb_addr_in == w_rs2_addr)) begin
      w_rs2_cap = wb_data_in;
    end
  end

  // Stage FSM with registered instruction, operands and valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_instr    <= 32'd0;
      r_rs1_data <= 32'd0;
      r_rs2_data <= 32'd0;
      r_op_valid <= 1'b0;
    end else if (flush_in) begin
      // Squash only the control state; captured data is left as is.
      r_state    <= S_IDLE;
      r_op_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid_in) begin
            r_instr <= instr_in;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (!w_wb_eff) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_rs1_data <= w_rs1_cap;
          r_rs2_data <= w_rs2_cap;
          r_op_valid <= 1'b1;
          r_state    <= S_VALID;
        end
        S_VALID: begin
          // w_wb_eff already excludes x0, so a match implies a nonzero source.
          if (w_wb_eff && (wb_addr_in == w_rs1_addr)) begin
            r_rs1_data <= wb_data_in;
          end
          if (w_wb_eff && (wb_addr_in == w_rs2_addr)) begin
            r_rs2_data <= wb_data_in;
          end
          if (op_ready_in) begin
            r_op_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_op_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
